// File: rtl/wb_master_arbiter_pkg.sv
// wb_master_arbiter shared types: FSM state encoding,
// burst lengths and default stall timeout.
package wb_master_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int BURST_LEN_4     = 4;
  localparam int BURST_LEN_8     = 8;
  localparam int BURST_CNT_W     = 4;
  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_master_arbiter_rr_priority_picker.sv
// Round-robin picker: first requester after last_i (mod N).
// Ports: req_i request vector, last_i last owner index, grant_o one-hot.
module rr_priority_picker #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_i) + k) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS cache masters onto one inner bus.
// Ports: m_wb_* master side, s_wb_* inner bus, o_grant owner; WB_ARB_TIMEOUT_EN adds stall timeout.
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif

module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = `WB_ADDR_W,
  parameter int DATA_W      = 16,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_MASTERS-1:0]        m_wb_cyc,
  input  logic [NUM_MASTERS-1:0]        m_wb_stb,
  input  logic [NUM_MASTERS-1:0]        m_wb_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_wb_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wb_o_dat,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_wb_sel,
  input  logic [NUM_MASTERS-1:0]        m_wb_4_burst,
  input  logic [NUM_MASTERS-1:0]        m_wb_8_burst,
  output logic [DATA_W-1:0]             m_wb_i_dat,
  output logic [NUM_MASTERS-1:0]        m_wb_ack,
  output logic [NUM_MASTERS-1:0]        m_wb_err,
  output logic                          s_wb_cyc,
  output logic                          s_wb_stb,
  output logic                          s_wb_we,
  output logic [ADDR_W-1:0]             s_wb_adr,
  output logic [DATA_W-1:0]             s_wb_o_dat,
  output logic [SEL_W-1:0]              s_wb_sel,
  output logic                          s_wb_4_burst,
  output logic                          s_wb_8_burst,
  input  logic [DATA_W-1:0]             s_wb_i_dat,
  input  logic                          s_wb_ack,
  input  logic                          s_wb_err,
  output logic [NUM_MASTERS-1:0]        o_grant
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("wb_master_arbiter: bad parameters");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, pick;
  logic [IW-1:0]          last_q, last_d, pick_idx;
  logic [BURST_CNT_W-1:0] bcnt_q, bcnt_d, blen;
  logic                   started_q, started_d;
  logic                   busy, own_cyc;
  logic                   to_fire, kill;

  rr_priority_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req_i   (m_wb_cyc),
    .last_i  (last_q),
    .grant_o (pick)
  );

  always_comb begin
    pick_idx = last_q;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (pick[i]) pick_idx = IW'(i);
  end

  // last_q doubles as the owner index while BUSY
  assign busy    = (state_q == ARB_BUSY);
  assign own_cyc = busy & m_wb_cyc[last_q];

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt_q;
  logic          to_q;

  assign to_fire = own_cyc & ~to_q
                 & (to_cnt_q == TW'(TIMEOUT));
  // bus stays cut off from the fire cycle until release
  assign kill    = to_q | to_fire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      if (!busy || s_wb_ack || s_wb_err)
        to_cnt_q <= '0;
      else if (s_wb_stb && to_cnt_q != TW'(TIMEOUT))
        to_cnt_q <= to_cnt_q + 1'b1;
      to_q <= own_cyc & (to_q | to_fire);
    end
  end
`else
  assign to_fire = 1'b0;
  assign kill    = 1'b0;
`endif

  assign s_wb_cyc     = own_cyc & ~kill;
  assign s_wb_stb     = own_cyc & m_wb_stb[last_q] & ~kill;
  assign s_wb_we      = busy & m_wb_we[last_q];
  assign s_wb_4_burst = busy & m_wb_4_burst[last_q];
  assign s_wb_8_burst = busy & m_wb_8_burst[last_q];
  assign s_wb_adr     = busy ? m_wb_adr[last_q*ADDR_W +: ADDR_W] : '0;
  assign s_wb_o_dat   = busy ? m_wb_o_dat[last_q*DATA_W +: DATA_W] : '0;
  assign s_wb_sel     = busy ? m_wb_sel[last_q*SEL_W +: SEL_W] : '0;

  assign m_wb_i_dat = s_wb_i_dat;
  assign m_wb_ack   = grant_q & {NUM_MASTERS{s_wb_ack}};
  assign m_wb_err   = grant_q & {NUM_MASTERS{s_wb_err | to_fire}};
  assign o_grant    = grant_q;

  // 8-beat hint wins when both are set
  always_comb begin
    blen = '0;
    if (s_wb_8_burst)      blen = BURST_CNT_W'(BURST_LEN_8);
    else if (s_wb_4_burst) blen = BURST_CNT_W'(BURST_LEN_4);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    bcnt_d    = bcnt_q;
    started_d = started_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|m_wb_cyc) begin
          state_d = ARB_BUSY;
          grant_d = pick;
          last_d  = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (!m_wb_cyc[last_q]) begin
          state_d   = ARB_IDLE;
          grant_d   = '0;
          bcnt_d    = '0;
          started_d = 1'b0;
        end else begin
          started_d = started_q | s_wb_stb;
          if (s_wb_err)
            bcnt_d = '0;
          else if (s_wb_stb && !started_q && blen != '0)
            bcnt_d = blen - BURST_CNT_W'(s_wb_ack);
          else if (s_wb_ack && bcnt_q != '0)
            bcnt_d = bcnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      last_q    <= IW'(NUM_MASTERS - 1);
      bcnt_q    <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      bcnt_q    <= bcnt_d;
      started_q <= started_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: directed scenarios
// plus randomized traffic against a round-robin reference model.
module tb_wb_master_arbiter;

  localparam int N  = 3;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_wb_cyc, m_wb_stb, m_wb_we;
  logic [N*AW-1:0] m_wb_adr;
  logic [N*DW-1:0] m_wb_o_dat;
  logic [N*SW-1:0] m_wb_sel;
  logic [N-1:0]    m_wb_4_burst, m_wb_8_burst;
  logic [DW-1:0]   m_wb_i_dat;
  logic [N-1:0]    m_wb_ack, m_wb_err;
  logic            s_wb_cyc, s_wb_stb, s_wb_we;
  logic [AW-1:0]   s_wb_adr;
  logic [DW-1:0]   s_wb_o_dat;
  logic [SW-1:0]   s_wb_sel;
  logic            s_wb_4_burst, s_wb_8_burst;
  logic [DW-1:0]   s_wb_i_dat;
  logic            s_wb_ack, s_wb_err;
  logic [N-1:0]    o_grant;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .SEL_W       (SW),
    .TIMEOUT     (8)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .m_wb_cyc     (m_wb_cyc),
    .m_wb_stb     (m_wb_stb),
    .m_wb_we      (m_wb_we),
    .m_wb_adr     (m_wb_adr),
    .m_wb_o_dat   (m_wb_o_dat),
    .m_wb_sel     (m_wb_sel),
    .m_wb_4_burst (m_wb_4_burst),
    .m_wb_8_burst (m_wb_8_burst),
    .m_wb_i_dat   (m_wb_i_dat),
    .m_wb_ack     (m_wb_ack),
    .m_wb_err     (m_wb_err),
    .s_wb_cyc     (s_wb_cyc),
    .s_wb_stb     (s_wb_stb),
    .s_wb_we      (s_wb_we),
    .s_wb_adr     (s_wb_adr),
    .s_wb_o_dat   (s_wb_o_dat),
    .s_wb_sel     (s_wb_sel),
    .s_wb_4_burst (s_wb_4_burst),
    .s_wb_8_burst (s_wb_8_burst),
    .s_wb_i_dat   (s_wb_i_dat),
    .s_wb_ack     (s_wb_ack),
    .s_wb_err     (s_wb_err),
    .o_grant      (o_grant)
  );

  task automatic clear_inputs();
    m_wb_cyc = '0; m_wb_stb = '0; m_wb_we = '0;
    m_wb_adr = '0; m_wb_o_dat = '0; m_wb_sel = '0;
    m_wb_4_burst = '0; m_wb_8_burst = '0;
    s_wb_i_dat = '0; s_wb_ack = 1'b0; s_wb_err = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    m_wb_cyc = 3'b111; m_wb_stb = 3'b111;
    s_wb_ack = 1'b1; s_wb_err = 1'b1;
    #1;
    tests++; if (o_grant !== 3'b000) begin fails++;
      $display("FAIL reset_grant got %b exp 000", o_grant); end
    tests++; if ({s_wb_cyc, s_wb_stb} !== 2'b00) begin fails++;
      $display("FAIL reset_scyc got %b exp 00", {s_wb_cyc, s_wb_stb}); end
    tests++; if ({m_wb_ack, m_wb_err} !== 6'b0) begin fails++;
      $display("FAIL reset_resp got %b exp 0", {m_wb_ack, m_wb_err}); end
    reset_dut();
  endtask

  task automatic test_single();
    reset_dut();
    m_wb_cyc[1] = 1'b1; m_wb_stb[1] = 1'b1;
    m_wb_adr[1*AW +: AW] = 24'h000100;
    #1;
    tests++; if (s_wb_cyc !== 1'b0) begin fails++;
      $display("FAIL single_latency got %b exp 0", s_wb_cyc); end
    @(negedge clk); #1;
    tests++; if (o_grant !== 3'b010) begin fails++;
      $display("FAIL single_grant got %b exp 010", o_grant); end
    tests++; if (s_wb_cyc !== 1'b1 || s_wb_adr !== 24'h000100) begin fails++;
      $display("FAIL single_bus got cyc=%b adr=%h exp 1/000100", s_wb_cyc, s_wb_adr); end
    s_wb_ack = 1'b1; s_wb_i_dat = 16'hBEEF;
    #1;
    tests++; if (m_wb_ack !== 3'b010) begin fails++;
      $display("FAIL single_ack got %b exp 010", m_wb_ack); end
    tests++; if (m_wb_i_dat !== 16'hBEEF) begin fails++;
      $display("FAIL single_dat got %h exp BEEF", m_wb_i_dat); end
    @(negedge clk);
    s_wb_ack = 1'b0; m_wb_cyc[1] = 1'b0; m_wb_stb[1] = 1'b0;
    #1;
    tests++; if (s_wb_cyc !== 1'b0 || o_grant !== 3'b010) begin fails++;
      $display("FAIL single_drop got cyc=%b g=%b exp 0/010", s_wb_cyc, o_grant); end
    @(negedge clk); #1;
    tests++; if (o_grant !== 3'b000) begin fails++;
      $display("FAIL single_release got %b exp 000", o_grant); end
  endtask

  task automatic test_rr_order();
    logic [N-1:0] eg;
    reset_dut();
    m_wb_cyc = 3'b111; m_wb_stb = 3'b111;
    for (int i = 0; i < 6; i++) begin
      eg = 3'b001 << (i % 3);
      @(negedge clk); #1;
      tests++; if (o_grant !== eg || s_wb_cyc !== 1'b1) begin fails++;
        $display("FAIL rr_grant%0d got %b exp %b", i, o_grant, eg); end
      s_wb_ack = 1'b1; #1;
      tests++; if (m_wb_ack !== eg) begin fails++;
        $display("FAIL rr_ack%0d got %b exp %b", i, m_wb_ack, eg); end
      @(negedge clk);
      s_wb_ack = 1'b0;
      m_wb_cyc[i % 3] = 1'b0; m_wb_stb[i % 3] = 1'b0;
      @(negedge clk); #1;
      tests++; if (o_grant !== 3'b000 || s_wb_cyc !== 1'b0) begin fails++;
        $display("FAIL rr_idle%0d got g=%b cyc=%b exp 000/0", i, o_grant, s_wb_cyc); end
      m_wb_cyc[i % 3] = 1'b1; m_wb_stb[i % 3] = 1'b1;
    end
    clear_inputs();
  endtask

  task automatic test_burst();
    reset_dut();
    m_wb_cyc[2] = 1'b1; m_wb_stb[2] = 1'b1; m_wb_we[2] = 1'b1;
    m_wb_4_burst[2] = 1'b1; m_wb_o_dat[2*DW +: DW] = 16'h1234;
    m_wb_sel[2*SW +: SW] = 2'b11;
    @(negedge clk);
    m_wb_cyc[0] = 1'b1; m_wb_stb[0] = 1'b1;
    #1;
    tests++; if (o_grant !== 3'b100) begin fails++;
      $display("FAIL burst_grant got %b exp 100", o_grant); end
    tests++; if ({s_wb_we, s_wb_4_burst, s_wb_o_dat, s_wb_sel} !== {2'b11, 16'h1234, 2'b11}) begin
      fails++; $display("FAIL burst_bus got we=%b b4=%b dat=%h sel=%b exp 1/1/1234/11",
        s_wb_we, s_wb_4_burst, s_wb_o_dat, s_wb_sel); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); #1;
      tests++; if (dut.bcnt_q !== 4'(4 - b) || o_grant !== 3'b100) begin fails++;
        $display("FAIL burst_beat%0d got cnt=%0d g=%b exp %0d/100", b, dut.bcnt_q, o_grant, 4 - b); end
      s_wb_ack = 1'b1; #1;
      tests++; if (m_wb_ack !== 3'b100) begin fails++;
        $display("FAIL burst_ack%0d got %b exp 100", b, m_wb_ack); end
    end
    @(negedge clk);
    s_wb_ack = 1'b0;
    m_wb_cyc[2] = 1'b0; m_wb_stb[2] = 1'b0;
    #1;
    tests++; if (dut.bcnt_q !== 4'd0 || s_wb_cyc !== 1'b0) begin fails++;
      $display("FAIL burst_end got cnt=%0d cyc=%b exp 0/0", dut.bcnt_q, s_wb_cyc); end
    @(negedge clk); #1;
    tests++; if (o_grant !== 3'b000) begin fails++;
      $display("FAIL burst_idle got %b exp 000", o_grant); end
    @(negedge clk); #1;
    tests++; if (o_grant !== 3'b001) begin fails++;
      $display("FAIL burst_next got %b exp 001", o_grant); end
    clear_inputs();
  endtask

  task automatic test_err();
    reset_dut();
    m_wb_cyc = 3'b011; m_wb_stb[0] = 1'b1; m_wb_8_burst[0] = 1'b1;
    @(negedge clk); #1;
    tests++; if (o_grant !== 3'b001) begin fails++;
      $display("FAIL err_grant got %b exp 001", o_grant); end
    @(negedge clk); #1;
    tests++; if (dut.bcnt_q !== 4'd8) begin fails++;
      $display("FAIL err_load got %0d exp 8", dut.bcnt_q); end
    s_wb_err = 1'b1; #1;
    tests++; if (m_wb_err !== 3'b001 || m_wb_ack !== 3'b000) begin fails++;
      $display("FAIL err_route got err=%b ack=%b exp 001/000", m_wb_err, m_wb_ack); end
    @(negedge clk);
    s_wb_err = 1'b0; #1;
    tests++; if (dut.bcnt_q !== 4'd0 || o_grant !== 3'b001) begin fails++;
      $display("FAIL err_hold got cnt=%0d g=%b exp 0/001", dut.bcnt_q, o_grant); end
    m_wb_cyc[0] = 1'b0; m_wb_stb[0] = 1'b0;
    @(negedge clk); #1;
    tests++; if (o_grant !== 3'b000) begin fails++;
      $display("FAIL err_release got %b exp 000", o_grant); end
    @(negedge clk); #1;
    tests++; if (o_grant !== 3'b010) begin fails++;
      $display("FAIL err_next got %b exp 010", o_grant); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    m_wb_cyc[0] = 1'b1; m_wb_stb[0] = 1'b1; m_wb_8_burst[0] = 1'b1;
    @(negedge clk);
    @(negedge clk); s_wb_ack = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    tests++; if (s_wb_cyc !== 1'b0 || o_grant !== 3'b000) begin fails++;
      $display("FAIL rstmid_bus got cyc=%b g=%b exp 0/000", s_wb_cyc, o_grant); end
    tests++; if (m_wb_ack !== 3'b000) begin fails++;
      $display("FAIL rstmid_ack got %b exp 000", m_wb_ack); end
    @(negedge clk);
    rst_n = 1'b1; s_wb_ack = 1'b0; m_wb_cyc[1] = 1'b1;
    @(negedge clk); #1;
    tests++; if (o_grant !== 3'b001) begin fails++;
      $display("FAIL rstmid_first got %b exp 001", o_grant); end
    clear_inputs();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    reset_dut();
    m_wb_cyc = 3'b110; m_wb_stb[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      tests++; if (m_wb_err !== 3'b000 || s_wb_cyc !== 1'b1) begin fails++;
        $display("FAIL to_stall%0d got err=%b cyc=%b exp 000/1", k, m_wb_err, s_wb_cyc); end
    end
    @(negedge clk); #1;
    tests++; if (m_wb_err !== 3'b010 || s_wb_cyc !== 1'b0) begin fails++;
      $display("FAIL to_fire got err=%b cyc=%b exp 010/0", m_wb_err, s_wb_cyc); end
    @(negedge clk); #1;
    tests++; if (m_wb_err !== 3'b000 || s_wb_cyc !== 1'b0 || o_grant !== 3'b010) begin fails++;
      $display("FAIL to_hold got err=%b cyc=%b g=%b exp 000/0/010", m_wb_err, s_wb_cyc, o_grant); end
    m_wb_cyc[1] = 1'b0; m_wb_stb[1] = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    tests++; if (o_grant !== 3'b100) begin fails++;
      $display("FAIL to_next got %b exp 100", o_grant); end
    clear_inputs();
  endtask
`endif

  // Reference: owner index (-1 = none), last owner, acks each master still wants
  task automatic test_random();
    int own, last, stall;
    int rem [N];
    logic [N-1:0] eg;
    logic ecyc;
    reset_dut();
    own = -1; last = N - 1; stall = 0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (m_wb_cyc[i]) begin
          if (own == i && rem[i] == 0) m_wb_cyc[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          m_wb_cyc[i] = 1'b1;
          rem[i] = 1 + $urandom_range(3);
          m_wb_we[i] = 1'($urandom_range(1));
          m_wb_adr[i*AW +: AW] = AW'($urandom);
          m_wb_o_dat[i*DW +: DW] = DW'($urandom);
          m_wb_sel[i*SW +: SW] = SW'($urandom);
          m_wb_4_burst[i] = 1'($urandom_range(1));
          m_wb_8_burst[i] = 1'($urandom_range(1));
        end
      end
      m_wb_stb = m_wb_cyc;
      ecyc = (own >= 0) && m_wb_cyc[own];
      s_wb_ack = ecyc && (stall >= 4 || $urandom_range(1) == 1);
      stall = (ecyc && !s_wb_ack) ? stall + 1 : 0;
      s_wb_i_dat = DW'($urandom);
      eg = (own >= 0) ? (N'(1) << own) : '0;
      #1;
      tests++; if (o_grant !== eg) begin fails++;
        $display("FAIL rnd_grant t=%0d got %b exp %b", t, o_grant, eg); end
      tests++; if (s_wb_cyc !== ecyc) begin fails++;
        $display("FAIL rnd_cyc t=%0d got %b exp %b", t, s_wb_cyc, ecyc); end
      tests++; if (m_wb_ack !== (s_wb_ack ? eg : N'(0))) begin fails++;
        $display("FAIL rnd_ack t=%0d got %b exp %b", t, m_wb_ack, s_wb_ack ? eg : N'(0)); end
      tests++; if (m_wb_i_dat !== s_wb_i_dat) begin fails++;
        $display("FAIL rnd_dat t=%0d got %h exp %h", t, m_wb_i_dat, s_wb_i_dat); end
      if (ecyc) begin
        tests++;
        if (s_wb_adr !== m_wb_adr[own*AW +: AW] || s_wb_we !== m_wb_we[own]
            || s_wb_o_dat !== m_wb_o_dat[own*DW +: DW] || s_wb_sel !== m_wb_sel[own*SW +: SW]) begin
          fails++;
          $display("FAIL rnd_mux t=%0d got adr=%h we=%b dat=%h sel=%b exp adr=%h", t,
            s_wb_adr, s_wb_we, s_wb_o_dat, s_wb_sel, m_wb_adr[own*AW +: AW]);
        end
      end
      if (ecyc && s_wb_ack) rem[own]--;
      if (own < 0) begin
        for (int k = 1; k <= N; k++)
          if (own < 0 && m_wb_cyc[(last + k) % N]) own = (last + k) % N;
        if (own >= 0) last = own;
      end else if (!m_wb_cyc[own]) begin
        own = -1;
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_rr_order();
    test_burst();
    test_err();
    test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
